// File: rtl/bti_arb2.sv
// Two-master BTI arbiter with an in-order ID FIFO that routes each slave response to its owner.
// Optional macro BTI_ARB_RR_EN selects round-robin arbitration; otherwise m0 has fixed priority.
module bti_arb2 #(
  parameter int BTI_AW    = 32,
  parameter int BTI_DW    = 32,
  parameter int OST_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_vld,
  output logic                m0_req_rdy,
  input  logic [BTI_AW-1:0]   m0_req_addr,
  input  logic                m0_req_wr,
  input  logic [BTI_DW-1:0]   m0_req_wdata,
  input  logic [BTI_DW/8-1:0] m0_req_strb,
  output logic                m0_rsp_vld,
  input  logic                m0_rsp_rdy,
  output logic [BTI_DW-1:0]   m0_rsp_data,
  input  logic                m1_req_vld,
  output logic                m1_req_rdy,
  input  logic [BTI_AW-1:0]   m1_req_addr,
  input  logic                m1_req_wr,
  input  logic [BTI_DW-1:0]   m1_req_wdata,
  input  logic [BTI_DW/8-1:0] m1_req_strb,
  output logic                m1_rsp_vld,
  input  logic                m1_rsp_rdy,
  output logic [BTI_DW-1:0]   m1_rsp_data,
  output logic                s_req_vld,
  input  logic                s_req_rdy,
  output logic [BTI_AW-1:0]   s_req_addr,
  output logic                s_req_wr,
  output logic [BTI_DW-1:0]   s_req_wdata,
  output logic [BTI_DW/8-1:0] s_req_strb,
  input  logic                s_rsp_vld,
  output logic                s_rsp_rdy,
  input  logic [BTI_DW-1:0]   s_rsp_data
);

  localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int CNT_W = $clog2(OST_DEPTH) + 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (OST_DEPTH == 1) return '0;
    return p + PTR_W'(1);
  endfunction

  logic             hold;
  logic             hold_idx;
  logic             win_idx;
  logic             win_vld;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OST_DEPTH-1:0] id_mem;

`ifdef BTI_ARB_RR_EN
  logic rr_ptr;
`endif

  // A stalled request keeps its grant so the slave sees a stable payload.
  always_comb begin
    win_idx = 1'b0;
    if (hold) begin
      win_idx = hold_idx;
    end else if (m0_req_vld && m1_req_vld) begin
`ifdef BTI_ARB_RR_EN
      win_idx = rr_ptr;
`else
      win_idx = 1'b0;
`endif
    end else begin
      win_idx = m1_req_vld;
    end
  end

  assign win_vld    = win_idx ? m1_req_vld : m0_req_vld;
  assign fifo_full  = (count == CNT_W'(OST_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = id_mem[rd_ptr];

  assign s_req_vld   = win_vld && !fifo_full && !rst;
  assign m0_req_rdy  = !win_idx && s_req_rdy && !fifo_full && !rst;
  assign m1_req_rdy  = win_idx && s_req_rdy && !fifo_full && !rst;
  assign s_req_addr  = win_idx ? m1_req_addr  : m0_req_addr;
  assign s_req_wr    = win_idx ? m1_req_wr    : m0_req_wr;
  assign s_req_wdata = win_idx ? m1_req_wdata : m0_req_wdata;
  assign s_req_strb  = win_idx ? m1_req_strb  : m0_req_strb;

  assign m0_rsp_vld  = s_rsp_vld && !fifo_empty && !head && !rst;
  assign m1_rsp_vld  = s_rsp_vld && !fifo_empty && head && !rst;
  assign s_rsp_rdy   = (head ? m1_rsp_rdy : m0_rsp_rdy) && !fifo_empty && !rst;
  assign m0_rsp_data = s_rsp_data;
  assign m1_rsp_data = s_rsp_data;

  assign push = s_req_vld && s_req_rdy;
  assign pop  = s_rsp_vld && s_rsp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= 1'b0;
      hold_idx <= 1'b0;
    end else begin
      hold <= s_req_vld && !s_req_rdy;
      if (s_req_vld && !s_req_rdy) hold_idx <= win_idx;
    end
  end

`ifdef BTI_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= 1'b0;
    else if (push) rr_ptr <= ~win_idx;
  end
`endif

  // ID FIFO: owner bit per outstanding transaction, popped in request order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= win_idx;
  end

  a_rsp_when_empty: assert property (@(posedge clk) disable iff (rst) !(s_rsp_vld && fifo_empty));

endmodule

// File: tb/tb_bti_arb2.sv
// Directed self-checking bench for bti_arb2; the bench itself plays the slave.
module tb_bti_arb2;

`ifdef BTI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        m0_req_vld, m0_req_rdy, m0_req_wr, m0_rsp_vld, m0_rsp_rdy;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_data;
  logic [3:0]  m0_req_strb;
  logic        m1_req_vld, m1_req_rdy, m1_req_wr, m1_rsp_vld, m1_rsp_rdy;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_data;
  logic [3:0]  m1_req_strb;
  logic        s_req_vld, s_req_rdy, s_req_wr, s_rsp_vld, s_rsp_rdy;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_data;
  logic [3:0]  s_req_strb;

  int checks = 0;
  int failures = 0;

  bti_arb2 #(.BTI_AW(32), .BTI_DW(32), .OST_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_wr(m0_req_wr), .m0_req_wdata(m0_req_wdata), .m0_req_strb(m0_req_strb),
    .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_data(m0_rsp_data),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_wr(m1_req_wr), .m1_req_wdata(m1_req_wdata), .m1_req_strb(m1_req_strb),
    .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_data(m1_rsp_data),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
    .s_req_wr(s_req_wr), .s_req_wdata(s_req_wdata), .s_req_strb(s_req_strb),
    .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_data(s_rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req_vld = 1'b1; m1_req_vld = 1'b1; s_req_rdy = 1'b1;
    m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1; s_rsp_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m0_req_rdy !== 1'b0) begin failures++; $display("FAIL rst_m0_req_rdy got=%b exp=0", m0_req_rdy); end
    checks++; if (m1_req_rdy !== 1'b0) begin failures++; $display("FAIL rst_m1_req_rdy got=%b exp=0", m1_req_rdy); end
    checks++; if (s_req_vld !== 1'b0) begin failures++; $display("FAIL rst_s_req_vld got=%b exp=0", s_req_vld); end
    checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL rst_s_rsp_rdy got=%b exp=0", s_rsp_rdy); end
    rst = 1'b0;
    m0_req_vld = 1'b0; m1_req_vld = 1'b0; s_req_rdy = 1'b0;
    #1;
    checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL post_rst_empty_s_rsp_rdy got=%b exp=0", s_rsp_rdy); end
    checks++; if (m0_rsp_vld !== 1'b0) begin failures++; $display("FAIL post_rst_m0_rsp_vld got=%b exp=0", m0_rsp_vld); end
    cyc();
  endtask

  task automatic test_single();
    m0_req_vld = 1'b1; m0_req_addr = 32'h10; m0_req_wr = 1'b0; s_req_rdy = 1'b1;
    #1;
    checks++; if (s_req_vld !== 1'b1) begin failures++; $display("FAIL single_s_req_vld got=%b exp=1", s_req_vld); end
    checks++; if (s_req_addr !== 32'h10) begin failures++; $display("FAIL single_s_req_addr got=%h exp=00000010", s_req_addr); end
    checks++; if (m0_req_rdy !== 1'b1) begin failures++; $display("FAIL single_m0_req_rdy got=%b exp=1", m0_req_rdy); end
    checks++; if (m1_req_rdy !== 1'b0) begin failures++; $display("FAIL single_m1_req_rdy got=%b exp=0", m1_req_rdy); end
    checks++; if (s_req_wr !== 1'b0) begin failures++; $display("FAIL single_s_req_wr got=%b exp=0", s_req_wr); end
    cyc();
    m0_req_vld = 1'b0;
    s_rsp_vld = 1'b1; s_rsp_data = 32'hDEADBEEF;
    #1;
    checks++; if (m0_rsp_vld !== 1'b1) begin failures++; $display("FAIL single_m0_rsp_vld got=%b exp=1", m0_rsp_vld); end
    checks++; if (m1_rsp_vld !== 1'b0) begin failures++; $display("FAIL single_m1_rsp_vld got=%b exp=0", m1_rsp_vld); end
    checks++; if (m0_rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_m0_rsp_data got=%h exp=deadbeef", m0_rsp_data); end
    checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL single_s_rsp_rdy got=%b exp=1", s_rsp_rdy); end
    cyc();
    s_rsp_vld = 1'b0;
    #1;
    checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL single_drained_s_rsp_rdy got=%b exp=0", s_rsp_rdy); end
  endtask

  task automatic test_contention();
    logic exp_idx, prev_idx;
    logic [31:0] exp_addr, exp_data;
    prev_idx = 1'b0;
    m0_req_vld = 1'b1; m0_req_addr = 32'h100;
    m1_req_vld = 1'b1; m1_req_addr = 32'h200; m1_req_wr = 1'b0;
    s_req_rdy = 1'b1; m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_idx  = RR ? k[0] : 1'b0;
      exp_addr = exp_idx ? 32'h200 : 32'h100;
      exp_data = 32'hA000_0000 + k;
      s_rsp_vld = (k > 0); s_rsp_data = exp_data;
      #1;
      checks++; if (s_req_addr !== exp_addr) begin failures++; $display("FAIL cont_grant_addr[%0d] got=%h exp=%h", k, s_req_addr, exp_addr); end
      checks++; if (m0_req_rdy !== !exp_idx) begin failures++; $display("FAIL cont_m0_req_rdy[%0d] got=%b exp=%b", k, m0_req_rdy, !exp_idx); end
      checks++; if (m1_req_rdy !== exp_idx) begin failures++; $display("FAIL cont_m1_req_rdy[%0d] got=%b exp=%b", k, m1_req_rdy, exp_idx); end
      if (k > 0) begin
        checks++; if (m0_rsp_vld !== !prev_idx) begin failures++; $display("FAIL cont_m0_rsp_vld[%0d] got=%b exp=%b", k, m0_rsp_vld, !prev_idx); end
        checks++; if (m1_rsp_vld !== prev_idx) begin failures++; $display("FAIL cont_m1_rsp_vld[%0d] got=%b exp=%b", k, m1_rsp_vld, prev_idx); end
      end
      cyc();
      prev_idx = exp_idx;
    end
    m0_req_vld = 1'b0; m1_req_vld = 1'b0;
    s_rsp_vld = 1'b1; s_rsp_data = 32'hA000_0004;
    #1;
    checks++; if (m1_rsp_vld !== prev_idx) begin failures++; $display("FAIL cont_last_m1_rsp_vld got=%b exp=%b", m1_rsp_vld, prev_idx); end
    checks++; if (m0_rsp_vld !== !prev_idx) begin failures++; $display("FAIL cont_last_m0_rsp_vld got=%b exp=%b", m0_rsp_vld, !prev_idx); end
    checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL cont_last_s_rsp_rdy got=%b exp=1", s_rsp_rdy); end
    cyc();
    s_rsp_vld = 1'b0;
  endtask

  task automatic test_hold();
    m1_req_vld = 1'b1; m1_req_addr = 32'h300; m1_req_wr = 1'b1;
    m1_req_wdata = 32'h12345678; m1_req_strb = 4'h5;
    s_req_rdy = 1'b0;
    #1;
    checks++; if (s_req_wr !== 1'b1) begin failures++; $display("FAIL hold_s_req_wr got=%b exp=1", s_req_wr); end
    checks++; if (s_req_wdata !== 32'h12345678) begin failures++; $display("FAIL hold_s_req_wdata got=%h exp=12345678", s_req_wdata); end
    checks++; if (s_req_strb !== 4'h5) begin failures++; $display("FAIL hold_s_req_strb got=%h exp=5", s_req_strb); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (s_req_addr !== 32'h300) begin failures++; $display("FAIL hold_addr[%0d] got=%h exp=00000300", k, s_req_addr); end
      checks++; if (s_req_vld !== 1'b1) begin failures++; $display("FAIL hold_s_req_vld[%0d] got=%b exp=1", k, s_req_vld); end
      checks++; if (m0_req_rdy !== 1'b0) begin failures++; $display("FAIL hold_m0_req_rdy[%0d] got=%b exp=0", k, m0_req_rdy); end
      cyc();
      m0_req_vld = 1'b1; m0_req_addr = 32'h400; m0_req_wr = 1'b0;
    end
    s_req_rdy = 1'b1;
    #1;
    checks++; if (s_req_addr !== 32'h300) begin failures++; $display("FAIL hold_release_addr got=%h exp=00000300", s_req_addr); end
    checks++; if (m1_req_rdy !== 1'b1) begin failures++; $display("FAIL hold_release_m1_rdy got=%b exp=1", m1_req_rdy); end
    checks++; if (m0_req_rdy !== 1'b0) begin failures++; $display("FAIL hold_release_m0_rdy got=%b exp=0", m0_req_rdy); end
    cyc();
    m1_req_vld = 1'b0; m1_req_wr = 1'b0;
    #1;
    checks++; if (s_req_addr !== 32'h400) begin failures++; $display("FAIL hold_next_addr got=%h exp=00000400", s_req_addr); end
    checks++; if (m0_req_rdy !== 1'b1) begin failures++; $display("FAIL hold_next_m0_rdy got=%b exp=1", m0_req_rdy); end
    cyc();
    m0_req_vld = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    // Outstanding order from the previous scenario: m1 then m0.
    m1_rsp_rdy = 1'b0; m0_rsp_rdy = 1'b1;
    s_rsp_vld = 1'b1; s_rsp_data = 32'h0000_0011;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL bp_s_rsp_rdy[%0d] got=%b exp=0", k, s_rsp_rdy); end
      checks++; if (m1_rsp_vld !== 1'b1) begin failures++; $display("FAIL bp_m1_rsp_vld[%0d] got=%b exp=1", k, m1_rsp_vld); end
      checks++; if (m0_rsp_vld !== 1'b0) begin failures++; $display("FAIL bp_m0_rsp_vld[%0d] got=%b exp=0", k, m0_rsp_vld); end
      checks++; if (m1_rsp_data !== 32'h11) begin failures++; $display("FAIL bp_m1_rsp_data[%0d] got=%h exp=00000011", k, m1_rsp_data); end
      cyc();
    end
    m1_rsp_rdy = 1'b1;
    #1;
    checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_s_rsp_rdy got=%b exp=1", s_rsp_rdy); end
    cyc();
    s_rsp_data = 32'h0000_0022;
    #1;
    checks++; if (m0_rsp_vld !== 1'b1) begin failures++; $display("FAIL bp_next_m0_rsp_vld got=%b exp=1", m0_rsp_vld); end
    checks++; if (m1_rsp_vld !== 1'b0) begin failures++; $display("FAIL bp_next_m1_rsp_vld got=%b exp=0", m1_rsp_vld); end
    cyc();
    s_rsp_vld = 1'b0;
  endtask

  task automatic test_full();
    s_req_rdy = 1'b1; m0_rsp_rdy = 1'b1;
    m0_req_vld = 1'b1; m0_req_addr = 32'h20;
    cyc();
    m0_req_addr = 32'h24;
    #1;
    checks++; if (m0_req_rdy !== 1'b1) begin failures++; $display("FAIL full_second_rdy got=%b exp=1", m0_req_rdy); end
    cyc();
    m0_req_addr = 32'h28;
    #1;
    checks++; if (m0_req_rdy !== 1'b0) begin failures++; $display("FAIL full_third_rdy got=%b exp=0", m0_req_rdy); end
    checks++; if (s_req_vld !== 1'b0) begin failures++; $display("FAIL full_s_req_vld got=%b exp=0", s_req_vld); end
    cyc();
    s_rsp_vld = 1'b1; s_rsp_data = 32'h0000_0033;
    #1;
    checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL full_pop_s_rsp_rdy got=%b exp=1", s_rsp_rdy); end
    checks++; if (m0_req_rdy !== 1'b0) begin failures++; $display("FAIL full_pop_cycle_rdy got=%b exp=0", m0_req_rdy); end
    cyc();
    s_rsp_vld = 1'b0;
    #1;
    checks++; if (m0_req_rdy !== 1'b1) begin failures++; $display("FAIL full_after_pop_rdy got=%b exp=1", m0_req_rdy); end
    checks++; if (s_req_addr !== 32'h28) begin failures++; $display("FAIL full_after_pop_addr got=%h exp=00000028", s_req_addr); end
    cyc();
  endtask

  task automatic test_reset_mid();
    // Two reads outstanding and m0 still requesting.
    m0_req_addr = 32'h2C;
    #1;
    checks++; if (m0_req_rdy !== 1'b0) begin failures++; $display("FAIL rmid_pre_full_rdy got=%b exp=0", m0_req_rdy); end
    rst = 1'b1; s_rsp_vld = 1'b1;
    #1;
    checks++; if (s_req_vld !== 1'b0) begin failures++; $display("FAIL rmid_s_req_vld got=%b exp=0", s_req_vld); end
    checks++; if (m0_rsp_vld !== 1'b0) begin failures++; $display("FAIL rmid_m0_rsp_vld got=%b exp=0", m0_rsp_vld); end
    checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL rmid_s_rsp_rdy got=%b exp=0", s_rsp_rdy); end
    cyc();
    rst = 1'b0; s_rsp_vld = 1'b0;
    m0_req_addr = 32'h50;
    #1;
    checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL rmid_empty_s_rsp_rdy got=%b exp=0", s_rsp_rdy); end
    checks++; if (m0_req_rdy !== 1'b1) begin failures++; $display("FAIL rmid_fresh_rdy got=%b exp=1", m0_req_rdy); end
    cyc();
    m0_req_vld = 1'b0;
    s_rsp_vld = 1'b1; s_rsp_data = 32'hCAFEF00D;
    #1;
    checks++; if (m0_rsp_vld !== 1'b1) begin failures++; $display("FAIL rmid_rsp_vld got=%b exp=1", m0_rsp_vld); end
    checks++; if (m0_rsp_data !== 32'hCAFEF00D) begin failures++; $display("FAIL rmid_rsp_data got=%h exp=cafef00d", m0_rsp_data); end
    checks++; if (m1_rsp_vld !== 1'b0) begin failures++; $display("FAIL rmid_m1_rsp_vld got=%b exp=0", m1_rsp_vld); end
    cyc();
    s_rsp_vld = 1'b0;
    #1;
    checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL rmid_final_empty got=%b exp=0", s_rsp_rdy); end
  endtask

  initial begin
    rst = 1'b1;
    m0_req_vld = 1'b0; m0_req_addr = '0; m0_req_wr = 1'b0; m0_req_wdata = '0; m0_req_strb = '0; m0_rsp_rdy = 1'b0;
    m1_req_vld = 1'b0; m1_req_addr = '0; m1_req_wr = 1'b0; m1_req_wdata = '0; m1_req_strb = '0; m1_rsp_rdy = 1'b0;
    s_req_rdy = 1'b0; s_rsp_vld = 1'b0; s_rsp_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_rsp_backpressure();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
